// File: rtl/stack_engine_pkg.sv
// stack_engine_pkg: constants, colour codes and FSM states shared by
// the stack game state block and the VGA draw path.
package stack_engine_pkg;

    localparam logic [9:0] WIDTH        = 10'd100;
    localparam logic [9:0] HEIGHT_RATIO = 10'd20;
    localparam logic [9:0] BASE_Y       = 10'd400;
    localparam logic [9:0] H_RES        = 10'd640;
    localparam logic [9:0] V_RES        = 10'd480;

    localparam logic [9:0] LAND_MIN = 10'd80;
    localparam logic [9:0] POS_HOME = 10'd270;
    localparam logic [9:0] POS_MAX  = H_RES - WIDTH;
    localparam int         LAYERS   = 16;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [1:0] CLR_NONE  = 2'b00;
    localparam logic [1:0] CLR_GREEN = 2'b01;
    localparam logic [1:0] CLR_RED   = 2'b10;
    localparam logic [1:0] CLR_BLUE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_FALL,
        ST_OVER
    } state_t;

    function automatic logic [9:0] abs_diff(input logic [9:0] a,
                                            input logic [9:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/stack_lfsr.sv
// stack_lfsr: free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1)
// used to pick the spawn column and colour of each falling block.
module stack_lfsr
    import stack_engine_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/stack_engine.sv
// stack_engine: tray, 16-layer colour stack and falling block state.
// Build option STACK_SPEEDUP_EN: fall step grows by height[4:2] px/tick.
module stack_engine
    import stack_engine_pkg::*;
#(
    parameter int MOVE_STEP = 4,
    parameter int FALL_STEP = 2,
    parameter int CATCH     = 50,
    parameter int MAX_MISS  = 3
) (
    input  logic        dclk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic [9:0]  pos_x,
    output logic [31:0] colors,
    output logic [9:0]  fall_x,
    output logic [9:0]  fall_y,
    output logic [1:0]  fall_clr,
    output logic [4:0]  height,
    output logic [1:0]  misses,
    output logic        game_over,
    output logic        win
);

    localparam logic [9:0] MOVE     = 10'(MOVE_STEP);
    localparam logic [9:0] CATCH_PX = 10'(CATCH);

    state_t     state;
    logic [7:0] lfsr;
    logic [9:0] step;
    logic [9:0] ny;
    logic [9:0] h_px;
    logic [9:0] land_y;
    logic [9:0] pos_nx;
    logic [1:0] spawn_clr;
    logic       hit;
    logic       lost;

    stack_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (dclk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    always_comb begin
`ifdef STACK_SPEEDUP_EN
        step = 10'(FALL_STEP) + {7'd0, height[4:2]};
`else
        step = 10'(FALL_STEP);
`endif
        ny   = fall_y + step;
        h_px = {5'd0, height} * HEIGHT_RATIO;
        // Guard the subtraction so a tall stack clamps instead of wrapping.
        land_y = (h_px > BASE_Y - LAND_MIN) ? LAND_MIN : BASE_Y - h_px;
        hit  = (fall_y < land_y) && (ny >= land_y) &&
               (abs_diff(fall_x, pos_x) < CATCH_PX);
        lost = (ny >= V_RES);

        pos_nx = pos_x;
        if (btn_l && !btn_r) begin
            pos_nx = (pos_x >= MOVE) ? pos_x - MOVE : 10'd0;
        end else if (btn_r && !btn_l) begin
            pos_nx = (pos_x >= POS_MAX - MOVE) ? POS_MAX : pos_x + MOVE;
        end

        spawn_clr = (lfsr[1:0] == CLR_NONE) ? CLR_GREEN : lfsr[1:0];
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pos_x     <= POS_HOME;
            colors    <= '0;
            fall_x    <= '0;
            fall_y    <= '0;
            fall_clr  <= CLR_NONE;
            height    <= '0;
            misses    <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_SPAWN;
                end
                ST_SPAWN: begin
                    fall_x   <= {1'b0, lfsr, 1'b0};
                    fall_y   <= '0;
                    fall_clr <= spawn_clr;
                    state    <= ST_FALL;
                end
                ST_FALL: begin
                    if (tick) begin
                        pos_x  <= pos_nx;
                        fall_y <= ny;
                        if (hit) begin
                            colors[{height[3:0], 1'b0} +: 2] <= fall_clr;
                            height   <= height + 5'd1;
                            fall_clr <= CLR_NONE;
                            if (height == 5'(LAYERS - 1)) begin
                                win   <= 1'b1;
                                state <= ST_OVER;
                            end else begin
                                state <= ST_SPAWN;
                            end
                        end else if (lost) begin
                            misses   <= misses + 2'd1;
                            fall_clr <= CLR_NONE;
                            if (misses == 2'(MAX_MISS - 1)) begin
                                game_over <= 1'b1;
                                state     <= ST_OVER;
                            end else begin
                                state <= ST_SPAWN;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        colors    <= '0;
                        height    <= '0;
                        misses    <= '0;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                        pos_x     <= POS_HOME;
                        state     <= ST_SPAWN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: table vectors, directed corner sequences and random
// stimulus checked against a behavioural game model.
module tb_stack_engine;

    localparam int WIDTH        = 100;
    localparam int HEIGHT_RATIO = 20;
    localparam int BASE_Y       = 400;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int MOVE_STEP    = 4;
    localparam int FALL_STEP    = 2;
    localparam int CATCH        = 50;
    localparam int MAX_MISS     = 3;

    localparam int M_IDLE  = 0;
    localparam int M_SPAWN = 1;
    localparam int M_FALL  = 2;
    localparam int M_OVER  = 3;

    logic        dclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        btn_l = 1'b0;
    logic        btn_r = 1'b0;
    logic [9:0]  pos_x;
    logic [31:0] colors;
    logic [9:0]  fall_x;
    logic [9:0]  fall_y;
    logic [1:0]  fall_clr;
    logic [4:0]  height;
    logic [1:0]  misses;
    logic        game_over;
    logic        win;

    stack_engine dut (
        .dclk      (dclk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .pos_x     (pos_x),
        .colors    (colors),
        .fall_x    (fall_x),
        .fall_y    (fall_y),
        .fall_clr  (fall_clr),
        .height    (height),
        .misses    (misses),
        .game_over (game_over),
        .win       (win)
    );

    always #5 dclk = ~dclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural game model
    int m_state, m_pos, m_fx, m_fy, m_clr, m_h, m_miss, m_go, m_win, m_lfsr;
    int m_stack[16];

    function automatic int lfsr_next(input int v);
        int fb;
        fb = v & 1;
        v  = v >> 1;
        if (fb != 0) v = v ^ 'hB8;
        return v;
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int fall_step();
`ifdef STACK_SPEEDUP_EN
        return FALL_STEP + m_h / 4;
`else
        return FALL_STEP;
`endif
    endfunction

    function automatic int land_y();
        int l;
        l = BASE_Y - HEIGHT_RATIO * m_h;
        if (l < 80) l = 80;
        return l;
    endfunction

    function automatic bit would_catch();
        int ny;
        ny = m_fy + fall_step();
        return (m_fy < land_y()) && (ny >= land_y()) &&
               (abs_i(m_fx - m_pos) < CATCH);
    endfunction

    function automatic logic [31:0] m_colors();
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c[2*i +: 2] = 2'(m_stack[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_pos = 270; m_fx = 0; m_fy = 0; m_clr = 0;
        m_h = 0; m_miss = 0; m_go = 0; m_win = 0; m_lfsr = 'hA5;
        for (int i = 0; i < 16; i++) m_stack[i] = 0;
    endtask

    task automatic model_step();
        int  ny;
        bit  caught;
        case (m_state)
            M_IDLE: if (start) m_state = M_SPAWN;
            M_SPAWN: begin
                m_fx = 2 * m_lfsr;
                m_fy = 0;
                m_clr = (m_lfsr % 4 == 0) ? 1 : m_lfsr % 4;
                m_state = M_FALL;
            end
            M_FALL: if (tick) begin
                ny = m_fy + fall_step();
                caught = would_catch();
                if (btn_l && !btn_r)
                    m_pos = (m_pos - MOVE_STEP < 0) ? 0 : m_pos - MOVE_STEP;
                else if (btn_r && !btn_l)
                    m_pos = (m_pos + MOVE_STEP > H_RES - WIDTH) ?
                            H_RES - WIDTH : m_pos + MOVE_STEP;
                m_fy = ny;
                if (caught) begin
                    m_stack[m_h] = m_clr;
                    m_h++;
                    m_clr = 0;
                    if (m_h == 16) begin m_win = 1; m_state = M_OVER; end
                    else m_state = M_SPAWN;
                end else if (ny >= V_RES) begin
                    m_miss++;
                    m_clr = 0;
                    if (m_miss == MAX_MISS) begin m_go = 1; m_state = M_OVER; end
                    else m_state = M_SPAWN;
                end
            end
            M_OVER: if (start) begin
                for (int i = 0; i < 16; i++) m_stack[i] = 0;
                m_h = 0; m_miss = 0; m_go = 0; m_win = 0; m_pos = 270;
                m_state = M_SPAWN;
            end
            default: m_state = M_IDLE;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge dclk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge dclk);
            if (rst_n) begin
                check("model_pos_x", 32'(pos_x), 32'(m_pos));
                check("model_colors", colors, m_colors());
                check("model_fall_x", 32'(fall_x), 32'(m_fx));
                check("model_fall_y", 32'(fall_y), 32'(m_fy));
                check("model_fall_clr", 32'(fall_clr), 32'(m_clr));
                check("model_height", 32'(height), 32'(m_h));
                check("model_misses", 32'(misses), 32'(m_miss));
                check("model_game_over", 32'(game_over), 32'(m_go));
                check("model_win", 32'(win), 32'(m_win));
            end
        end
    end

    task automatic check_reset_vals(input string p);
        check({p, "_pos_x"}, 32'(pos_x), 32'd270);
        check({p, "_colors"}, colors, 32'd0);
        check({p, "_fall_x"}, 32'(fall_x), 32'd0);
        check({p, "_fall_y"}, 32'(fall_y), 32'd0);
        check({p, "_fall_clr"}, 32'(fall_clr), 32'd0);
        check({p, "_height"}, 32'(height), 32'd0);
        check({p, "_misses"}, 32'(misses), 32'd0);
        check({p, "_game_over"}, 32'(game_over), 32'd0);
        check({p, "_win"}, 32'(win), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge dclk);
        rst_n = 1'b0; start = 0; tick = 0; btn_l = 0; btn_r = 0;
        repeat (3) @(negedge dclk);
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    // Pulse start so the following SPAWN latches lfsr == target.
    task automatic start_when(input int target);
        int k;
        k = 0;
        @(negedge dclk);
        while (lfsr_next(m_lfsr) != target && k < 400) begin
            @(negedge dclk);
            k++;
        end
        check("start_sync", 32'(k < 400), 32'd1);
        start = 1'b1;
        @(negedge dclk);
        start = 1'b0;
        @(negedge dclk);
    endtask

    task automatic do_ticks(input int n, input bit l, input bit r);
        int done, guard;
        done = 0; guard = 0;
        btn_l = l; btn_r = r;
        while (done < n && guard < 4 * n + 20) begin
            tick = (m_state == M_FALL);
            if (tick) done++;
            @(negedge dclk);
            guard++;
        end
        tick = 0; btn_l = 0; btn_r = 0;
        check("ticks_applied", 32'(done), 32'(n));
    endtask

    typedef struct {
        bit l;
        bit r;
        int n;
        int exp_pos;
    } tray_vec_t;

    tray_vec_t tv[9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int zero_layers;
        int nxt;

        tv[0] = '{1'b1, 1'b1, 10, 270};
        tv[1] = '{1'b0, 1'b0, 5, 270};
        tv[2] = '{1'b1, 1'b0, 100, 0};
        tv[3] = '{1'b1, 1'b0, 5, 0};
        tv[4] = '{1'b0, 1'b1, 10, 40};
        tv[5] = '{1'b0, 1'b1, 200, 540};
        tv[6] = '{1'b0, 1'b1, 3, 540};
        tv[7] = '{1'b1, 1'b0, 1, 536};
        tv[8] = '{1'b1, 1'b1, 4, 536};

        // Reset and IDLE ignoring ticks/buttons
        do_reset();
        tick = 1; btn_r = 1;
        repeat (5) @(negedge dclk);
        tick = 0; btn_r = 0;
        check("idle_pos_x", 32'(pos_x), 32'd270);
        check("idle_fall_clr", 32'(fall_clr), 32'd0);

        // Miss: fall_x=200 vs tray 270 is never caught
        start_when(100);
        check("miss_fall_x", 32'(fall_x), 32'd200);
        check("miss_fall_y0", 32'(fall_y), 32'd0);
        check("miss_clr_00_to_green", 32'(fall_clr), 32'd1);
        do_ticks(239, 0, 0);
        check("miss_fall_y478", 32'(fall_y), 32'd478);
        check("miss_not_yet", 32'(misses), 32'd0);
        do_ticks(1, 0, 0);
        check("miss_count1", 32'(misses), 32'd1);
        check("miss_clr_cleared", 32'(fall_clr), 32'd0);
        check("miss_height", 32'(height), 32'd0);
        @(negedge dclk);
        check("miss_respawn_y", 32'(fall_y), 32'd0);
        check("miss_respawn_vis", 32'(fall_clr != 2'b00), 32'd1);

        // Catch: fall_x=250 vs tray 270
        do_reset();
        start_when(125);
        check("catch_fall_x", 32'(fall_x), 32'd250);
        do_ticks(199, 0, 0);
        check("catch_pre_y", 32'(fall_y), 32'd398);
        check("catch_pre_h", 32'(height), 32'd0);
        do_ticks(1, 0, 0);
        check("catch_height", 32'(height), 32'd1);
        check("catch_colors", colors, 32'h0000_0001);
        check("catch_clr_cleared", 32'(fall_clr), 32'd0);
        @(negedge dclk);
        check("catch_respawn_y", 32'(fall_y), 32'd0);
        check("catch_respawn_vis", 32'(fall_clr != 2'b00), 32'd1);

        // Tray vectors: clamping and both-buttons hold
        for (int i = 0; i < 9; i++) begin
            do_ticks(tv[i].n, tv[i].l, tv[i].r);
            check($sformatf("tray_vec%0d", i), 32'(pos_x), 32'(tv[i].exp_pos));
        end

        // Random play against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            tick  = 1'($urandom_range(0, 1));
            btn_l = 1'($urandom_range(0, 1));
            btn_r = 1'($urandom_range(0, 1));
            @(negedge dclk);
        end
        start = 0; tick = 0; btn_l = 0; btn_r = 0;

        // Fill: time each catching tick so the next block spawns over the tray
        do_reset();
        start_when(135);
        check("fill_first_x", 32'(fall_x), 32'd270);
        guard = 0;
        while (m_state != M_OVER && guard < 20000) begin
            nxt = 2 * lfsr_next(m_lfsr);
            tick = (m_state == M_FALL) &&
                   (!would_catch() || abs_i(nxt - m_pos) < 40);
            @(negedge dclk);
            guard++;
        end
        tick = 0;
        check("fill_done", 32'(guard < 20000), 32'd1);
        check("fill_height", 32'(height), 32'd16);
        check("fill_win", 32'(win), 32'd1);
        check("fill_no_loss", 32'(game_over), 32'd0);
        zero_layers = 0;
        for (int i = 0; i < 16; i++)
            if (colors[2*i +: 2] == 2'b00) zero_layers++;
        check("fill_layers_full", 32'(zero_layers), 32'd0);
        tick = 1; btn_l = 1;
        repeat (20) @(negedge dclk);
        tick = 0; btn_l = 0;
        check("over_frozen_pos", 32'(pos_x), 32'd270);
        check("over_frozen_h", 32'(height), 32'd16);
        check("over_frozen_clr", 32'(fall_clr), 32'd0);
        start = 1;
        @(negedge dclk);
        start = 0;
        check("restart_colors", colors, 32'd0);
        check("restart_height", 32'(height), 32'd0);
        check("restart_win", 32'(win), 32'd0);
        @(negedge dclk);

        // Three misses: steer the tray away from every block
        guard = 0;
        while (m_go == 0 && guard < 5000) begin
            tick  = (m_state == M_FALL);
            btn_l = (m_fx >= 270);
            btn_r = (m_fx < 270);
            @(negedge dclk);
            guard++;
        end
        tick = 0; btn_l = 0; btn_r = 0;
        check("loss_done", 32'(guard < 5000), 32'd1);
        check("loss_game_over", 32'(game_over), 32'd1);
        check("loss_misses", 32'(misses), 32'd3);
        check("loss_height", 32'(height), 32'd0);

        // Asynchronous reset in the middle of a fall
        start = 1;
        @(negedge dclk);
        start = 0;
        @(negedge dclk);
        do_ticks(30, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        @(negedge dclk);
        rst_n = 1'b1;
        repeat (3) @(negedge dclk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Game-state producer for the VGA draw path.
- Owns the player tray position, the 16-layer packed colour stack, and the single falling block.
- Outputs drive the draw block's pos_x, colors, fall_x, fall_y and fall_clr inputs directly.
- Advances once per frame tick; catches, stacks, misses and game-over are all resolved here.

Parameters:
- WIDTH, 100: tray/block width in px; must match the draw path.
- HEIGHT_RATIO, 20: layer height in px.
- BASE_Y, 400: y of layer 0 top edge.
- H_RES, 640: screen width.
- V_RES, 480: screen height; a block whose fall_y reaches this is lost.
- MOVE_STEP, 4: tray px per tick while a button is held.
- FALL_STEP, 2: block px per tick.
- CATCH, 50: max |fall_x - pos_x| (exclusive) that counts as a catch.
- MAX_MISS, 3: misses that end the game.

Ports:
- dclk  in  1  system clock (same as draw path).
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle frame pulse (per VS).
- start  in  1  level; begins a game from IDLE/OVER.
- btn_l  in  1  level; move tray left.
- btn_r  in  1  level; move tray right.
- pos_x  out  10  tray/stack left edge.
- colors  out  32  layer i colour at [2i+1:2i]; 00 empty, 01 green, 10 red, 11 blue.
- fall_x  out  10  falling block left edge.
- fall_y  out  10  falling block top edge.
- fall_clr  out  2  falling block colour; 00 means invisible.
- height  out  5  stacked layers, 0..16.
- misses  out  2  miss count.
- game_over  out  1  high in OVER after a loss.
- win  out  1  high in OVER after the stack fills.

Behaviour:
- Reset (async, rst_n=0):
  - pos_x=270; colors=0; fall_x=0; fall_y=0; fall_clr=00; height=0; misses=0; game_over=0; win=0.
  - LFSR=8'hA5; state=IDLE.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1. Advances every dclk cycle regardless of state.
- FSM states: IDLE, SPAWN, FALL, OVER.
- IDLE:
  - Outputs hold reset values.
  - start=1 -> SPAWN on next edge.
- SPAWN (one cycle, tick not required):
  - fall_x={1'b0,lfsr,1'b0} (0..510).
  - fall_y=0.
  - fall_clr=lfsr[1:0]; if that is 00, use 01.
  - Next state FALL.
- FALL: acts only on cycles with tick=1.
  - Tray move:
    - btn_l only: pos_x=max(pos_x-MOVE_STEP,0).
    - btn_r only: pos_x=min(pos_x+MOVE_STEP,H_RES-WIDTH).
    - Both or neither: hold.
  - Block fall: ny=fall_y+step. land_y=BASE_Y-HEIGHT_RATIO*height, computed in 10 bits; minimum 80, never negative.
  - Catch condition: fall_y<land_y, ny>=land_y, and |fall_x-pos_x|<CATCH.
    - Catch uses the pre-update pos_x, i.e. the tray value registered before this tick's move.
    - On catch: colors[2h+1:2h]=fall_clr; height+1; fall_clr=00.
    - If the new height is 16: win=1 -> OVER. Otherwise -> SPAWN.
  - Block passing land_y without a catch keeps falling, and can no longer be caught.
  - Loss: ny>=V_RES -> misses+1, fall_clr=00.
    - If misses reaches MAX_MISS: game_over=1 -> OVER. Otherwise -> SPAWN.
  - Otherwise fall_y=ny.
- OVER:
  - All outputs frozen.
  - start=1 -> clear colors, height, misses, game_over, win; pos_x=270; -> SPAWN.
- start asserted in SPAWN/FALL is ignored.
- tick in IDLE/SPAWN/OVER is ignored.
- Catch and loss cannot coincide, because land_y<=BASE_Y<V_RES.
- All arithmetic is 10-bit unsigned. Subtraction is guarded by comparison before it is performed, so there is no wrap.

Optional Feature:
- STACK_SPEEDUP_EN defined: step=FALL_STEP+height[4:2] (0..4 extra px/tick as the stack grows).
- Undefined: step=FALL_STEP constant.
- The height output and all other behaviour are identical either way.

Decomposition:
- Shared package holds:
  - Colour codes CLR_NONE/CLR_GREEN/CLR_RED/CLR_BLUE.
  - WIDTH, HEIGHT_RATIO, BASE_Y, H_RES, V_RES as constants, shared with the draw path.
  - FSM state enum.
- One sub-module, stack_lfsr: 8-bit Galois LFSR with seed parameter and async active-low reset.

Test Plan:
- Reset then start, with lfsr giving fall_x=200, pos_x=270, no buttons:
  - Diff 70 >= CATCH.
  - Block passes 400 and reaches 480 after 240 ticks.
  - misses=1, then SPAWN.
- Catch: force fall_x=250, pos_x=270 (diff 20), height=0:
  - After 200 ticks fall_y reaches 400.
  - colors[1:0]=fall_clr, height=1, new spawn next cycle.
- Clamp: hold btn_l for 100 ticks from pos_x=270 -> pos_x=0 and stays 0. Hold btn_r -> saturates at 540.
- Both btn_l and btn_r held for 10 ticks -> pos_x unchanged at 270.
- Fill: catch 16 blocks -> height=16, win=1, state OVER, outputs frozen. start -> colors=0, height=0, win=0.
- Three consecutive misses -> game_over=1.
  - rst_n low mid-FALL -> all outputs return to reset values immediately, without waiting for a dclk edge.
